// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time meter: state encoding,
// default prescaler ratio and the top value of one decimal digit.
package reaction_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // 50 MHz clock -> 50000 cycles per millisecond
  localparam int TICKS_PER_MS_DEF = 50000;

  // Largest value a single BCD digit may hold
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the millisecond counter. clr wins over inc;
// carry is raised when an increment rolls the digit from 9 back to 0.
module bcd_digit
  import reaction_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value and carry into the next decade
  always_comb begin
    digit_d = digit_q;
    carry   = inc && (digit_q == BCD_MAX);
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/reaction_meter.sv
// Reaction-time meter: counts elapsed milliseconds while start_clock is
// high, pauses while it is low, and holds a saturating 3-digit BCD result
// once done_tick is seen.
module reaction_meter
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS = TICKS_PER_MS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_clock,
  input  logic       done_tick,
  input  logic       clear,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       busy,
  output logic       result_valid,
  output logic       valid_tick,
  output logic       too_slow
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            too_slow_q, too_slow_d;
  logic            valid_tick_q, valid_tick_d;

  logic            digit_clr;
  logic            ms_tick;
  logic            at_max;
  logic            inc0, inc1, inc2;
  logic            carry0, carry1;
  logic            unused_carry2;

  // Millisecond tick and saturation detect
  always_comb begin
    ms_tick = (state_q == ST_COUNT) && start_clock && (presc_q == PRESC_MAX);
    at_max  = (bcd2 == BCD_MAX) && (bcd1 == BCD_MAX) && (bcd0 == BCD_MAX);
  end

  // Increment chain; the units digit is withheld at 999 so the count saturates
  always_comb begin
    inc0 = ms_tick && !at_max;
    inc1 = carry0;
    inc2 = carry1;
  end

  // Next-state, prescaler, flag and digit-clear decode
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    too_slow_d   = too_slow_q;
    valid_tick_d = 1'b0;
    digit_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start_clock) begin
          digit_clr  = 1'b1;
          presc_d    = '0;
          too_slow_d = 1'b0;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (start_clock) begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
        if (ms_tick && at_max) begin
          too_slow_d = 1'b1;
        end
        if (done_tick) begin
          state_d      = ST_HOLD;
          valid_tick_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear) begin
      state_d      = ST_IDLE;
      presc_d      = '0;
      too_slow_d   = 1'b0;
      valid_tick_d = 1'b0;
      digit_clr    = 1'b1;
    end
  end

  // State, prescaler and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      too_slow_q   <= 1'b0;
      valid_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      too_slow_q   <= too_slow_d;
      valid_tick_q <= valid_tick_d;
    end
  end

  bcd_digit u_units (
    .clk   (clk),
    .reset (reset),
    .clr   (digit_clr),
    .inc   (inc0),
    .digit (bcd0),
    .carry (carry0)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .reset (reset),
    .clr   (digit_clr),
    .inc   (inc1),
    .digit (bcd1),
    .carry (carry1)
  );

  bcd_digit u_hundreds (
    .clk   (clk),
    .reset (reset),
    .clr   (digit_clr),
    .inc   (inc2),
    .digit (bcd2),
    .carry (unused_carry2)
  );

  assign busy         = (state_q == ST_COUNT);
  assign result_valid = (state_q == ST_HOLD);
  assign valid_tick   = valid_tick_q;
  assign too_slow     = too_slow_q;

endmodule
